// File: rtl/perceptron_host_link.sv
// Host-side initiator for the perceptron UART byte protocol: serialises one word-level
// request into command bytes, then gathers the responder's reply bytes into one response.
module perceptron_host_link #(
  parameter int unsigned TIMEOUT_CYCLES = 1200000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [1:0]  i_req_op,
  input  logic [15:0] i_req_word1,
  input  logic [15:0] i_req_word2,
  output logic        o_rsp_valid,
  output logic [15:0] o_rsp_word1,
  output logic [15:0] o_rsp_word2,
  output logic        o_rsp_error,
  output logic [7:0]  o_uart_byte,
  output logic        o_uart_send,
  input  logic        i_uart_busy,
  input  logic [7:0]  i_rx_byte,
  input  logic        i_rx_ready,
  output logic        o_uart_clear
);

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND    = 3'd1,
    S_GUARD   = 3'd2,
    S_WAIT_TX = 3'd3,
    S_RECV    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  function automatic logic [7:0] f_opcode(input logic [1:0] op);
    case (op)
      2'd0:    f_opcode = 8'h57;
      2'd1:    f_opcode = 8'h49;
      2'd2:    f_opcode = 8'h52;
      2'd3:    f_opcode = 8'h4F;
      default: f_opcode = 8'h00;
    endcase
  endfunction

  function automatic logic [2:0] f_tx_len(input logic [1:0] op);
    f_tx_len = op[1] ? 3'd1 : 3'd5;
  endfunction

  function automatic logic [2:0] f_rx_len(input logic [1:0] op);
    case (op)
      2'd0:    f_rx_len = 3'd1;
      2'd1:    f_rx_len = 3'd1;
      2'd2:    f_rx_len = 3'd4;
      2'd3:    f_rx_len = 3'd2;
      default: f_rx_len = 3'd1;
    endcase
  endfunction

  function automatic logic [7:0] f_frame_byte(input logic [1:0]  op,
                                              input logic [15:0] w1,
                                              input logic [15:0] w2,
                                              input logic [2:0]  idx);
    case (idx)
      3'd0:    f_frame_byte = f_opcode(op);
      3'd1:    f_frame_byte = w1[15:8];
      3'd2:    f_frame_byte = w1[7:0];
      3'd3:    f_frame_byte = w2[15:8];
      3'd4:    f_frame_byte = w2[7:0];
      default: f_frame_byte = 8'h00;
    endcase
  endfunction

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_op, w_op_nxt;
  logic [15:0] r_word1, w_word1_nxt;
  logic [15:0] r_word2, w_word2_nxt;
  logic [2:0]  r_tx_cnt, w_tx_cnt_nxt;
  logic        r_guard, w_guard_nxt;
  logic [2:0]  r_rx_cnt, w_rx_cnt_nxt;
  logic [31:0] r_rsp, w_rsp_nxt;
  logic        r_err, w_err_nxt;
  logic [31:0] r_to_cnt, w_to_cnt_nxt;

  logic        r_req_ready, w_req_ready_nxt;
  logic        r_rsp_valid, w_rsp_valid_nxt;
  logic [15:0] r_rsp_word1, w_rsp_word1_nxt;
  logic [15:0] r_rsp_word2, w_rsp_word2_nxt;
  logic        r_rsp_error, w_rsp_error_nxt;
  logic [7:0]  r_uart_byte, w_uart_byte_nxt;
  logic        r_uart_send, w_uart_send_nxt;
  logic        r_uart_clear, w_uart_clear_nxt;

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    w_state_nxt      = r_state;
    w_op_nxt         = r_op;
    w_word1_nxt      = r_word1;
    w_word2_nxt      = r_word2;
    w_tx_cnt_nxt     = r_tx_cnt;
    w_guard_nxt      = r_guard;
    w_rx_cnt_nxt     = r_rx_cnt;
    w_rsp_nxt        = r_rsp;
    w_err_nxt        = r_err;
    w_to_cnt_nxt     = r_to_cnt;
    w_rsp_valid_nxt  = 1'b0;
    w_rsp_word1_nxt  = r_rsp_word1;
    w_rsp_word2_nxt  = r_rsp_word2;
    w_rsp_error_nxt  = r_rsp_error;
    w_uart_byte_nxt  = r_uart_byte;
    w_uart_send_nxt  = 1'b0;
    w_uart_clear_nxt = 1'b0;
    w_req_ready_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_req_valid && r_req_ready) begin
          w_op_nxt     = i_req_op;
          w_word1_nxt  = i_req_word1;
          w_word2_nxt  = i_req_word2;
          w_tx_cnt_nxt = 3'd0;
          w_rx_cnt_nxt = 3'd0;
          w_rsp_nxt    = 32'd0;
          w_err_nxt    = 1'b0;
          w_to_cnt_nxt = 32'd0;
          w_state_nxt  = S_SEND;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_SEND: begin
        if (!i_uart_busy) begin
          w_uart_byte_nxt = f_frame_byte(r_op, r_word1, r_word2, r_tx_cnt);
          w_uart_send_nxt = 1'b1;
          w_tx_cnt_nxt    = r_tx_cnt + 3'd1;
          w_guard_nxt     = 1'b0;
          w_state_nxt     = S_GUARD;
        end else begin
          w_state_nxt = S_SEND;
        end
      end

      // The UART raises busy a cycle or two after the strobe, so busy is not trusted yet.
      S_GUARD: begin
        if (r_guard) begin
          w_state_nxt = S_WAIT_TX;
        end else begin
          w_guard_nxt = 1'b1;
        end
      end

      S_WAIT_TX: begin
        if (!i_uart_busy) begin
          if (r_tx_cnt < f_tx_len(r_op)) begin
            w_state_nxt = S_SEND;
          end else begin
            w_tx_cnt_nxt = 3'd0;
            w_rx_cnt_nxt = 3'd0;
            w_to_cnt_nxt = 32'd0;
            w_state_nxt  = S_RECV;
          end
        end else begin
          w_state_nxt = S_WAIT_TX;
        end
      end

      // rx_ready stays high during the clear cycle, so captures are skipped while clearing.
      S_RECV: begin
        if (i_rx_ready && !r_uart_clear) begin
          w_uart_clear_nxt = 1'b1;
          w_to_cnt_nxt     = 32'd0;
          w_rx_cnt_nxt     = r_rx_cnt + 3'd1;
          case (r_rx_cnt)
            3'd0:    w_rsp_nxt[31:24] = i_rx_byte;
            3'd1:    w_rsp_nxt[23:16] = i_rx_byte;
            3'd2:    w_rsp_nxt[15:8]  = i_rx_byte;
            3'd3:    w_rsp_nxt[7:0]   = i_rx_byte;
            default: w_rsp_nxt        = r_rsp;
          endcase
          if (!r_op[1] && (r_rx_cnt == 3'd0) && (i_rx_byte != f_opcode(r_op))) begin
            w_err_nxt = 1'b1;
          end else begin
            w_err_nxt = r_err;
          end
        end else if (r_uart_clear && (r_rx_cnt == f_rx_len(r_op))) begin
          w_state_nxt = S_DONE;
        end else if (r_to_cnt == TO_LAST) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 32'd1;
        end
      end

      S_DONE: begin
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
      w_rsp_valid_nxt = 1'b1;
      w_rsp_word1_nxt = r_op[1] ? w_rsp_nxt[31:16] : 16'd0;
      w_rsp_word2_nxt = (r_op == 2'd2) ? w_rsp_nxt[15:0] : 16'd0;
      w_rsp_error_nxt = w_err_nxt;
    end else begin
      w_rsp_valid_nxt = 1'b0;
    end

    w_req_ready_nxt = (w_state_nxt == S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_op         <= 2'd0;
      r_word1      <= 16'd0;
      r_word2      <= 16'd0;
      r_tx_cnt     <= 3'd0;
      r_guard      <= 1'b0;
      r_rx_cnt     <= 3'd0;
      r_rsp        <= 32'd0;
      r_err        <= 1'b0;
      r_to_cnt     <= 32'd0;
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_word1  <= 16'd0;
      r_rsp_word2  <= 16'd0;
      r_rsp_error  <= 1'b0;
      r_uart_byte  <= 8'd0;
      r_uart_send  <= 1'b0;
      r_uart_clear <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_op         <= w_op_nxt;
      r_word1      <= w_word1_nxt;
      r_word2      <= w_word2_nxt;
      r_tx_cnt     <= w_tx_cnt_nxt;
      r_guard      <= w_guard_nxt;
      r_rx_cnt     <= w_rx_cnt_nxt;
      r_rsp        <= w_rsp_nxt;
      r_err        <= w_err_nxt;
      r_to_cnt     <= w_to_cnt_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_word1  <= w_rsp_word1_nxt;
      r_rsp_word2  <= w_rsp_word2_nxt;
      r_rsp_error  <= w_rsp_error_nxt;
      r_uart_byte  <= w_uart_byte_nxt;
      r_uart_send  <= w_uart_send_nxt;
      r_uart_clear <= w_uart_clear_nxt;
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_word1  = r_rsp_word1;
  assign o_rsp_word2  = r_rsp_word2;
  assign o_rsp_error  = r_rsp_error;
  assign o_uart_byte  = r_uart_byte;
  assign o_uart_send  = r_uart_send;
  assign o_uart_clear = r_uart_clear;

endmodule
